dump_sender: RTL and testbench
==============================

# dump_sender

Consumer side of the capture unit's dump handshake. On a dump command it pulses `start_dump`, then for every sample the capture unit presents (`send_dump` high) it latches the selected channel's RAM byte and hands it to the UART transmitter. After `tx_done` it acknowledges with a one-cycle `dump_sent`. It finishes when the capture unit signals `dump_finished`, then reports completion to the command processor.

## Interface
Parameters:
- `CHANNELS`, default 3: number of RAM channel data inputs; `chan` selects among them.

Ports (single clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock
- `rst_n`  input  1  asynchronous active-low reset
- `dump_req`  input  1  one-cycle command strobe from command processor
- `chan`  input  2  channel to dump; sampled on accepted `dump_req`; values ≥ `CHANNELS` select channel 0
- `ch_data`  input  8×`CHANNELS`  RAM read data, channel i at bits [8i+7:8i]
- `start_dump`  output  1  one-cycle pulse to capture unit
- `send_dump`  input  1  capture unit: RAM data for current address valid, awaiting ack
- `dump_finished`  input  1  capture unit: last sample acknowledged (coincident with `dump_sent`)
- `dump_sent`  output  1  one-cycle ack that current byte was transmitted
- `tx_data`  output  8  byte to UART
- `trmt`  output  1  one-cycle UART transmit strobe
- `tx_done`  input  1  UART finished byte (pulse or level)
- `busy`  output  1  dump in progress
- `dump_cmplt`  output  1  one-cycle completion pulse to command processor
- `byte_cnt`  output  10  bytes sent in current or last dump

## Operation
States: IDLE, START, WAIT_DATA, WAIT_TX, ACK.
- IDLE: `dump_req` → latch `chan` into `chan_ff`, clear `byte_cnt`, go to START. Otherwise stay.
- START: assert `start_dump` for exactly one cycle, go to WAIT_DATA. `start_dump` must never be high for two consecutive cycles, because the capture unit treats it as a level and would restart.
- WAIT_DATA: on `send_dump`=1: register `tx_data` ← `ch_data[chan_ff]`, assert `trmt` next cycle (registered, one cycle), go to WAIT_TX. Otherwise stay; there is no timeout.
- WAIT_TX: ignore `tx_done` in the cycle `trmt` is high. On a later `tx_done`=1 go to ACK.
- ACK: drive `dump_sent`=1 for one cycle and increment `byte_cnt` (saturates at 1023). Sample `dump_finished` in this same cycle:
  - if 1: go to IDLE and pulse `dump_cmplt` next cycle.
  - else: go to WAIT_DATA.
- `busy` = (state ≠ IDLE).
- `dump_req` while `busy` is ignored. `chan` changes mid-dump have no effect.
- `tx_data` holds its value between bytes.

## Timing
- Reset values: `start_dump`=0, `dump_sent`=0, `trmt`=0, `tx_data`=0, `busy`=0, `dump_cmplt`=0, `byte_cnt`=0, state IDLE.
- `dump_req` at cycle N → `start_dump` high at N+1 only.
- `send_dump` first seen at cycle M (in WAIT_DATA) → `tx_data` valid and `trmt` high at M+1.
- `tx_done` at cycle T (T > M+1) → `dump_sent` high at T+1. `send_dump` may drop combinationally in that cycle.
- WAIT_DATA re-entered at T+2. The capture unit needs at least 2 cycles before reasserting `send_dump`, and no byte may be missed.
- `dump_finished` is valid only during the ACK cycle and is ignored elsewhere.
- `dump_cmplt` at T+2 for the final byte; `busy` low at T+2.
- Reset asserted mid-dump: all outputs return to reset values immediately, with no partial `dump_sent` or `trmt`. Re-triggering requires a new `dump_req`.
- Throughput: one byte per UART frame + 3 cycles.

## Test plan
- Reset, then `dump_req` with `chan`=1. `send_dump` presented with `ch_data`={0x33,0xA5,0x11}. Expect: `start_dump` one-cycle pulse; `tx_data`=0xA5; `trmt` one cycle; `tx_done` 20 cycles later → `dump_sent` next cycle. `dump_finished`=1 → `dump_cmplt`, `byte_cnt`=1.
- 512-byte dump with a capture model incrementing data 0x00..0xFF twice. Expect UART byte stream in order, 512 `dump_sent` pulses, `byte_cnt`=512, single `dump_cmplt`.
- `dump_req` repeated while `busy`. Expect no second `start_dump` and `chan` unchanged.
- `tx_done` asserted high as a level, already high at `trmt`. Expect the `trmt` cycle ignored and ack on the next high cycle. No double `dump_sent`.
- Reset asserted during WAIT_TX. Expect all outputs 0 asynchronously; after release, IDLE with no spurious `trmt`, `dump_sent` or `dump_cmplt`.
- `chan`=3 with `CHANNELS`=3. Expect channel 0 data transmitted.

Source files
------------

// File: rtl/dump_sender.sv
// -----------------------------------------------------------------------------
// dump_sender
//
// Reads a capture dump out over the UART. A dump command pulses start_dump
// to the capture unit. For every sample that the capture unit presents, the
// block latches the byte of the selected RAM channel and strobes the UART
// transmitter. When the UART finishes the byte, the block acknowledges it to
// the capture unit. When the capture unit flags the last sample, the block
// reports completion to the command processor.
//
// Parameters
//   CHANNELS       number of 8-bit RAM channels on ch_data
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   dump_req       one-cycle command strobe, accepted only when idle
//   chan           channel to dump, latched on an accepted dump_req
//   ch_data        RAM read data; channel i is at bits [8i+7:8i]
//   start_dump     one-cycle pulse to the capture unit
//   send_dump      capture unit: the current sample is valid and awaits an ack
//   dump_finished  capture unit: the sample being acked is the last one
//   dump_sent      one-cycle ack for the current sample
//   tx_data        byte for the UART; holds its value between bytes
//   trmt           one-cycle UART transmit strobe
//   tx_done        UART byte finished (either a pulse or a level)
//   busy           a dump is in progress
//   dump_cmplt     one-cycle completion pulse to the command processor
//   byte_cnt       bytes sent in the current or last dump (saturates at 1023)
//
// Handshake with the capture unit: send_dump is a request that stays high
// until it is acknowledged. The block takes the byte in the first WAIT_DATA
// cycle that sees send_dump high. It acknowledges with a single dump_sent
// cycle (the ACK state). dump_finished is sampled only in that ACK cycle.
// The capture unit may drop send_dump during ACK. WAIT_DATA is entered again
// on the cycle after ACK.
// -----------------------------------------------------------------------------
module dump_sender #(
  parameter int CHANNELS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dump_req,
  input  logic [1:0]            chan,
  input  logic [8*CHANNELS-1:0] ch_data,
  output logic                  start_dump,
  input  logic                  send_dump,
  input  logic                  dump_finished,
  output logic                  dump_sent,
  output logic [7:0]            tx_data,
  output logic                  trmt,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  dump_cmplt,
  output logic [9:0]            byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WAIT_TX   = 3'd3,
    S_ACK       = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_chan;
  logic [7:0]  r_tx_data;
  logic        r_trmt;
  logic        r_dump_cmplt;
  logic [9:0]  r_byte_cnt;
  logic [7:0]  w_sel_byte;

  // Channel mux. A channel number with no matching channel leaves the
  // default in place, so out-of-range selects read channel 0.
  always_comb begin
    w_sel_byte = ch_data[7:0];
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_chan == 2'(i)) begin
        w_sel_byte = ch_data[8*i +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (dump_req) w_next = S_START;
      // START always lasts exactly one cycle. The capture unit treats
      // start_dump as a level, so it must never be high for two cycles.
      S_START:     w_next = S_WAIT_DATA;
      S_WAIT_DATA: if (send_dump) w_next = S_WAIT_TX;
      // While trmt is high, tx_done still reflects the previous byte (a
      // level-style tx_done may still be high), so it is ignored.
      S_WAIT_TX:   if (tx_done && !r_trmt) w_next = S_ACK;
      S_ACK:       w_next = dump_finished ? S_IDLE : S_WAIT_DATA;
      default:     w_next = S_IDLE;
    endcase
  end

  // Datapath and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan       <= 2'd0;
      r_tx_data    <= 8'd0;
      r_trmt       <= 1'b0;
      r_dump_cmplt <= 1'b0;
      r_byte_cnt   <= 10'd0;
    end else begin
      r_trmt       <= 1'b0;
      r_dump_cmplt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_chan     <= chan;
            r_byte_cnt <= 10'd0;
          end
        end
        S_WAIT_DATA: begin
          if (send_dump) begin
            r_tx_data <= w_sel_byte;
            r_trmt    <= 1'b1;
          end
        end
        S_ACK: begin
          if (r_byte_cnt != 10'h3FF) begin
            r_byte_cnt <= r_byte_cnt + 10'd1;
          end
          if (dump_finished) begin
            r_dump_cmplt <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    start_dump = (r_state == S_START);
    dump_sent  = (r_state == S_ACK);
    busy       = (r_state != S_IDLE);
    trmt       = r_trmt;
    tx_data    = r_tx_data;
    dump_cmplt = r_dump_cmplt;
    byte_cnt   = r_byte_cnt;
  end

endmodule

// File: tb/tb_dump_sender.sv
// -----------------------------------------------------------------------------
// tb_dump_sender: directed self-checking bench for dump_sender (CHANNELS=3).
// Inputs change 1 ns after the rising edge. Outputs are read at that same
// point, or on the falling edge by the monitor.
// -----------------------------------------------------------------------------
module tb_dump_sender;

  logic        clk;
  logic        rst_n;
  logic        dump_req;
  logic [1:0]  chan;
  logic [23:0] ch_data;
  logic        start_dump;
  logic        send_dump;
  logic        dump_finished;
  logic        dump_sent;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        busy;
  logic        dump_cmplt;
  logic [9:0]  byte_cnt;

  int checks;
  int errors;

  // Scoreboard: bytes seen at each trmt, plus pulse counters
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int trmt_cnt;
  int sent_cnt;
  int start_cnt;
  int cmplt_cnt;

  dump_sender #(.CHANNELS(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dump_req      (dump_req),
    .chan          (chan),
    .ch_data       (ch_data),
    .start_dump    (start_dump),
    .send_dump     (send_dump),
    .dump_finished (dump_finished),
    .dump_sent     (dump_sent),
    .tx_data       (tx_data),
    .trmt          (trmt),
    .tx_done       (tx_done),
    .busy          (busy),
    .dump_cmplt    (dump_cmplt),
    .byte_cnt      (byte_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    if (trmt) begin
      trmt_cnt++;
      got_q.push_back(tx_data);
    end
    if (dump_sent)  sent_cnt++;
    if (start_dump) start_cnt++;
    if (dump_cmplt) cmplt_cnt++;
  end

  // ---------------------------------------------------------------- drivers
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n         = 1'b0;
    dump_req      = 1'b0;
    send_dump     = 1'b0;
    tx_done       = 1'b0;
    dump_finished = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  // Accept a dump command. On return the DUT is in its first WAIT_DATA cycle.
  task automatic start_cmd(input logic [1:0] c);
    chan     = c;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    step();
  endtask

  // Capture-unit and UART model for one sample. Call it in a WAIT_DATA cycle.
  // The UART finishes 'gap' cycles after the trmt cycle. On return the DUT
  // is at T+2: back in WAIT_DATA, or idle with dump_cmplt high.
  task automatic drive_byte(input bit last, input int gap);
    send_dump = 1'b1;
    step();
    repeat (gap) step();
    tx_done = 1'b1;
    step();
    tx_done       = 1'b0;
    send_dump     = 1'b0;
    dump_finished = last;
    step();
    dump_finished = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset;
    rst_n         = 1'b0;
    dump_req      = 1'b0;
    chan          = 2'd0;
    ch_data       = 24'd0;
    send_dump     = 1'b0;
    dump_finished = 1'b0;
    tx_done       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({start_dump, dump_sent, trmt, busy, dump_cmplt} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {start_dump, dump_sent, trmt, busy, dump_cmplt});
    end
    checks++;
    if (tx_data !== 8'h00 || byte_cnt !== 10'd0) begin
      errors++;
      $display("FAIL reset_data: tx_data=%h byte_cnt=%0d expected 00/0", tx_data, byte_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_byte;
    int s0, c0;
    apply_reset();
    ch_data = {8'h11, 8'hA5, 8'h33};
    s0 = start_cnt;
    c0 = cmplt_cnt;
    chan     = 2'd1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    chan     = 2'd2;
    checks++;
    if (start_dump !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start: start_dump=%b busy=%b expected 1/1", start_dump, busy);
    end
    step();
    checks++;
    if (start_dump !== 1'b0) begin
      errors++;
      $display("FAIL single_start_width: start_dump=%b expected 0", start_dump);
    end
    send_dump = 1'b1;
    step();
    checks++;
    if (trmt !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_trmt: trmt=%b tx_data=%h expected 1/a5", trmt, tx_data);
    end
    step();
    checks++;
    if (trmt !== 1'b0) begin
      errors++;
      $display("FAIL single_trmt_width: trmt=%b expected 0", trmt);
    end
    repeat (18) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++;
    if (dump_sent !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: dump_sent=%b expected 1", dump_sent);
    end
    dump_finished = 1'b1;
    send_dump     = 1'b0;
    step();
    dump_finished = 1'b0;
    checks++;
    if (dump_sent !== 1'b0 || dump_cmplt !== 1'b1 || busy !== 1'b0 || byte_cnt !== 10'd1) begin
      errors++;
      $display("FAIL single_done: sent=%b cmplt=%b busy=%b cnt=%0d expected 0/1/0/1",
               dump_sent, dump_cmplt, busy, byte_cnt);
    end
    step();
    checks++;
    if (dump_cmplt !== 1'b0 || start_cnt - s0 != 1 || cmplt_cnt - c0 != 1) begin
      errors++;
      $display("FAIL single_pulses: cmplt=%b starts=%0d cmplts=%0d expected 0/1/1",
               dump_cmplt, start_cnt - s0, cmplt_cnt - c0);
    end
  endtask

  task automatic test_long_dump;
    int s0, c0, bad;
    logic [7:0] b;
    apply_reset();
    got_q.delete();
    exp_q.delete();
    s0 = sent_cnt;
    c0 = cmplt_cnt;
    ch_data = 24'h000000;
    start_cmd(2'd1);
    for (int i = 0; i < 512; i++) begin
      b = 8'(i);
      ch_data[15:8] = b;
      exp_q.push_back(b);
      drive_byte(i == 511, 1 + (i % 3));
    end
    step();
    checks++;
    if (got_q.size() != 512) begin
      errors++;
      $display("FAIL long_count: got %0d bytes expected 512", got_q.size());
    end
    bad = 0;
    for (int i = 0; i < 512 && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (bad == 0) $display("FAIL long_stream: byte %0d got %h expected %h", i, got_q[i], exp_q[i]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (sent_cnt - s0 != 512 || byte_cnt !== 10'd512) begin
      errors++;
      $display("FAIL long_acks: dump_sent pulses=%0d byte_cnt=%0d expected 512/512",
               sent_cnt - s0, byte_cnt);
    end
    checks++;
    if (cmplt_cnt - c0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL long_cmplt: cmplt pulses=%0d busy=%b expected 1/0", cmplt_cnt - c0, busy);
    end
  endtask

  task automatic test_busy_ignore;
    int s0, c0;
    apply_reset();
    got_q.delete();
    ch_data = {8'h11, 8'hA5, 8'h33};
    s0 = start_cnt;
    c0 = cmplt_cnt;
    chan     = 2'd2;
    dump_req = 1'b1;
    step();
    chan = 2'd0;
    step();
    step();
    dump_req = 1'b0;
    drive_byte(1'b0, 1);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    drive_byte(1'b1, 3);
    step();
    step();
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL busy_start: start_dump pulses=%0d expected 1", start_cnt - s0);
    end
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h11 || got_q[got_q.size()-1] !== 8'h11) begin
      errors++;
      $display("FAIL busy_chan: %0d bytes first=%h expected 2 bytes of 11",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    checks++;
    if (cmplt_cnt - c0 != 1 || busy !== 1'b0 || byte_cnt !== 10'd2) begin
      errors++;
      $display("FAIL busy_end: cmplts=%0d busy=%b cnt=%0d expected 1/0/2",
               cmplt_cnt - c0, busy, byte_cnt);
    end
  endtask

  task automatic test_tx_done_level;
    int s0;
    apply_reset();
    ch_data = {8'h11, 8'hA5, 8'h33};
    s0 = sent_cnt;
    start_cmd(2'd0);
    tx_done   = 1'b1;
    send_dump = 1'b1;
    step();
    checks++;
    if (trmt !== 1'b1 || dump_sent !== 1'b0) begin
      errors++;
      $display("FAIL level_trmt: trmt=%b dump_sent=%b expected 1/0", trmt, dump_sent);
    end
    step();
    checks++;
    if (dump_sent !== 1'b0) begin
      errors++;
      $display("FAIL level_early_ack: dump_sent=%b expected 0", dump_sent);
    end
    step();
    checks++;
    if (dump_sent !== 1'b1) begin
      errors++;
      $display("FAIL level_ack: dump_sent=%b expected 1", dump_sent);
    end
    send_dump = 1'b0;
    step();
    step();
    checks++;
    if (sent_cnt - s0 != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL level_double: ack pulses=%0d busy=%b expected 1/1", sent_cnt - s0, busy);
    end
    tx_done = 1'b0;
    drive_byte(1'b1, 2);
    checks++;
    if (byte_cnt !== 10'd2 || dump_cmplt !== 1'b1) begin
      errors++;
      $display("FAIL level_end: byte_cnt=%0d cmplt=%b expected 2/1", byte_cnt, dump_cmplt);
    end
  endtask

  task automatic test_reset_mid_dump;
    int t0, a0, s0, c0;
    apply_reset();
    ch_data = {8'h11, 8'hA5, 8'h33};
    start_cmd(2'd1);
    drive_byte(1'b0, 1);
    send_dump = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_dump, dump_sent, trmt, busy, dump_cmplt} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_strobes: got %b expected 00000",
               {start_dump, dump_sent, trmt, busy, dump_cmplt});
    end
    checks++;
    if (tx_data !== 8'h00 || byte_cnt !== 10'd0) begin
      errors++;
      $display("FAIL midrst_data: tx_data=%h byte_cnt=%0d expected 00/0", tx_data, byte_cnt);
    end
    t0 = trmt_cnt;
    a0 = sent_cnt;
    s0 = start_cnt;
    c0 = cmplt_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_done       = i[0];
      dump_finished = 1'b1;
      step();
    end
    tx_done       = 1'b0;
    dump_finished = 1'b0;
    send_dump     = 1'b0;
    checks++;
    if (trmt_cnt != t0 || sent_cnt != a0 || start_cnt != s0 || cmplt_cnt != c0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: trmt=%0d sent=%0d start=%0d cmplt=%0d busy=%b expected 0/0/0/0/0",
               trmt_cnt - t0, sent_cnt - a0, start_cnt - s0, cmplt_cnt - c0, busy);
    end
  endtask

  task automatic test_chan_out_of_range;
    apply_reset();
    got_q.delete();
    ch_data = {8'h11, 8'hA5, 8'h33};
    start_cmd(2'd3);
    drive_byte(1'b1, 1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h33) begin
      errors++;
      $display("FAIL chan3: %0d bytes first=%h expected 1 byte of 33",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    trmt_cnt  = 0;
    sent_cnt  = 0;
    start_cnt = 0;
    cmplt_cnt = 0;
    test_reset();
    test_single_byte();
    test_busy_ignore();
    test_tx_done_level();
    test_reset_mid_dump();
    test_chan_out_of_range();
    test_long_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
